clock_reset_sequencer: RTL

// Parametrised PLL/MMCM supervisor for the top-level clocking. Drives each PLL's reset, watches its LOCKED output,
// and only gates the PLL's output clock on (BUFGCE CE) once lock has been stable for a filter window. It then holds
// and releases a per-domain synchronous reset. Lost lock is detected, recorded as sticky status, and handled by
// re-resetting the PLL. Relock timeouts trigger automatic retries. Runs on the free-running board refclk domain.
//

---
 rtl/clock_reset_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/clock_reset_sequencer.sv
// Supervises NUM_PLLS PLL channels: pulses each PLL reset, filters LOCKED, gates the output clock,
// then sequences a per-domain reset. Lock loss is made sticky and the channel re-sequences.
module clock_reset_sequencer #(
  parameter int NUM_PLLS     = 2,
  parameter int RST_PULSE    = 32,
  parameter int LOCK_TIMEOUT = 156250,
  parameter int LOCK_FILTER  = 1024,
  parameter int RST_HOLD     = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_PLLS-1:0]   pll_lock,
  output logic [NUM_PLLS-1:0]   pll_rst,
  output logic [NUM_PLLS-1:0]   clk_en,
  output logic [NUM_PLLS-1:0]   domain_rst,
  output logic                  all_ready,
  output logic [NUM_PLLS-1:0]   lock_lost,
  input  logic                  lock_lost_clr,
  output logic [8*NUM_PLLS-1:0] retry_count
);

  localparam int MAX_A   = (RST_PULSE > LOCK_TIMEOUT) ? RST_PULSE : LOCK_TIMEOUT;
  localparam int MAX_B   = (LOCK_FILTER > RST_HOLD) ? LOCK_FILTER : RST_HOLD;
  localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(MAX_CNT) + 1;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    FILTER    = 3'd2,
    CLK_ON    = 3'd3,
    RUN       = 3'd4
  } state_t;

  logic [NUM_PLLS-1:0] lock_meta_r;
  logic [NUM_PLLS-1:0] lock_sync_r;
  logic [NUM_PLLS-1:0] run_s;
  logic                all_ready_r;

  // Two-flop synchroniser for the asynchronous LOCKED inputs; deliberately left unreset.
  always_ff @(posedge clk) begin
    lock_meta_r <= pll_lock;
    lock_sync_r <= lock_meta_r;
  end

  for (genvar i = 0; i < NUM_PLLS; i++) begin : g_ch
    state_t        state_r;
    state_t        state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [7:0]    retry_r;
    logic          retry_inc_s;
    logic          loss_s;
    logic          lock_s;
    logic          pll_rst_r;
    logic          clk_en_r;
    logic          domain_rst_r;
    logic          lost_r;

    assign lock_s = lock_sync_r[i];

    // Next-state decode; loss is only flagged while the output clock is enabled.
    always_comb begin
      state_nxt_s = state_r;
      retry_inc_s = 1'b0;
      loss_s      = 1'b0;
      case (state_r)
        PLL_RST: begin
          if (cnt_r == CW'(RST_PULSE - 1)) state_nxt_s = WAIT_LOCK;
          else                             state_nxt_s = PLL_RST;
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_nxt_s = FILTER;
          end else if (cnt_r == CW'(LOCK_TIMEOUT - 1)) begin
            state_nxt_s = PLL_RST;
            retry_inc_s = 1'b1;
          end else begin
            state_nxt_s = WAIT_LOCK;
          end
        end
        FILTER: begin
          if (!lock_s)                              state_nxt_s = WAIT_LOCK;
          else if (cnt_r == CW'(LOCK_FILTER - 1))   state_nxt_s = CLK_ON;
          else                                      state_nxt_s = FILTER;
        end
        CLK_ON: begin
          if (!lock_s) begin
            state_nxt_s = PLL_RST;
            loss_s      = 1'b1;
          end else if (cnt_r == CW'(RST_HOLD - 1)) begin
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = CLK_ON;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_nxt_s = PLL_RST;
            loss_s      = 1'b1;
          end else begin
            state_nxt_s = RUN;
          end
        end
        default: state_nxt_s = PLL_RST;
      endcase
    end

    // State, cycle counter and state-decoded outputs; the counter idles at zero in RUN.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_r      <= PLL_RST;
        cnt_r        <= {CW{1'b0}};
        pll_rst_r    <= 1'b1;
        clk_en_r     <= 1'b0;
        domain_rst_r <= 1'b1;
        lost_r       <= 1'b0;
        retry_r      <= 8'd0;
      end else begin
        state_r <= state_nxt_s;
        if ((state_nxt_s != state_r) || (state_r == RUN)) cnt_r <= {CW{1'b0}};
        else                                              cnt_r <= cnt_r + CW'(1);
        pll_rst_r    <= (state_nxt_s == PLL_RST);
        clk_en_r     <= (state_nxt_s == CLK_ON) || (state_nxt_s == RUN);
        domain_rst_r <= (state_nxt_s != RUN);
        if (loss_s)             lost_r <= 1'b1;
        else if (lock_lost_clr) lost_r <= 1'b0;
        else                    lost_r <= lost_r;
        if (retry_inc_s && (retry_r != 8'd255)) retry_r <= retry_r + 8'd1;
        else                                    retry_r <= retry_r;
      end
    end

    assign run_s[i]             = (state_r == RUN);
    assign pll_rst[i]           = pll_rst_r;
    assign clk_en[i]            = clk_en_r;
    assign domain_rst[i]        = domain_rst_r;
    assign lock_lost[i]         = lost_r;
    assign retry_count[8*i +: 8] = retry_r;
  end

  // Readiness follows the channel states with one cycle of delay.
  always_ff @(posedge clk) begin
    if (rst) all_ready_r <= 1'b0;
    else     all_ready_r <= &run_s;
  end

  assign all_ready = all_ready_r;

endmodule
